// File: rtl/audionet_pkg.sv
// Shared definitions for the audio network framing blocks.
//   CH_W    : bits per channel sample
//   N_CH    : channels per TDM frame
//   FRAME_W : width of one assembled frame
//   chan_t  : channel index type
//   frame_t : full frame type
//   state_t : frame assembler state encoding (IDLE / FILL / FULL)
package audionet_pkg;

    localparam int CH_W    = 32;
    localparam int N_CH    = 8;
    localparam int FRAME_W = CH_W * N_CH;
    localparam int CHAN_W  = $clog2(N_CH);

    typedef logic [CHAN_W-1:0]  chan_t;
    typedef logic [FRAME_W-1:0] frame_t;

    // IDLE : block disabled or just enabled
    // FILL : accepting sample beats
    // FULL : period closed (all channels in or s_last seen), waiting for tick
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

endpackage

// File: rtl/tdm_frame_pack_merge.sv
// frame_merge: combinational frame builder used on the frame tick.
// Each output slice takes, in priority order:
//   1. the beat being accepted in this cycle, if it targets that slice
//   2. the assembled sample, if the channel arrived this period
//   3. the previous frame's slice (HOLD_ON_MISS=1) or zero (HOLD_ON_MISS=0)
// Ports:
//   asm_data   in   assembly buffer, one slice per channel
//   chan_mask  in   channels received this period
//   beat_en    in   a valid in-range beat is accepted this cycle
//   beat_chan  in   channel of that beat
//   beat_data  in   sample of that beat
//   old_pdata  in   currently presented frame
//   merged     out  frame to present next
//   eff_mask   out  chan_mask including the current beat
module frame_merge
    import audionet_pkg::*;
#(
    parameter int CHANNELS     = N_CH,
    parameter int WIDTH        = CH_W,
    parameter bit HOLD_ON_MISS = 1'b1
) (
    input  logic [CHANNELS-1:0][WIDTH-1:0] asm_data,
    input  logic [CHANNELS-1:0]            chan_mask,
    input  logic                           beat_en,
    input  chan_t                          beat_chan,
    input  logic [WIDTH-1:0]               beat_data,
    input  logic [CHANNELS-1:0][WIDTH-1:0] old_pdata,
    output logic [CHANNELS-1:0][WIDTH-1:0] merged,
    output logic [CHANNELS-1:0]            eff_mask
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_slice
            logic beat_hit;
            assign beat_hit     = beat_en && (beat_chan == chan_t'(gi));
            assign merged[gi]   = beat_hit      ? beat_data     :
                                  chan_mask[gi] ? asm_data[gi]  :
                                  HOLD_ON_MISS  ? old_pdata[gi] : '0;
            assign eff_mask[gi] = chan_mask[gi] | beat_hit;
        end
    endgenerate

endmodule

// File: rtl/tdm_frame_pack.sv
// tdm_frame_pack: gathers per-channel samples from a stream and presents one
// CHANNELS x WIDTH frame per frame_tick as a single-cycle valid with pdata,
// plus single-cycle count pulses for missing, duplicate and stalled samples.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   enable       block enable; low clears assembly state (pdata is held)
//   frame_tick   1-cycle frame-rate strobe
//   s_valid      sample beat valid
//   s_ready      sample beat ready (high only while filling and enabled)
//   s_chan       channel index of the beat
//   s_data       sample data
//   s_last       last beat of this frame period
//   valid        1-cycle frame valid, one cycle after frame_tick
//   pdata        frame, channel n at [n*WIDTH +: WIDTH]; held between valids
//   missIncr     frame emitted with at least one channel absent
//   dupIncr      a channel was written twice in one period (cycle after the beat)
//   overrunIncr  the source was stalled during the period just closed
module tdm_frame_pack
    import audionet_pkg::*;
#(
    parameter int CHANNELS     = N_CH,
    parameter int WIDTH        = CH_W,
    parameter bit HOLD_ON_MISS = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      frame_tick,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  chan_t                     s_chan,
    input  logic [WIDTH-1:0]          s_data,
    input  logic                      s_last,
    output logic                      valid,
    output logic [CHANNELS*WIDTH-1:0] pdata,
    output logic                      missIncr,
    output logic                      dupIncr,
    output logic                      overrunIncr
);

    localparam logic [CHANNELS-1:0] FULL_MASK = '1;

    state_t                         state_reg;
    logic [CHANNELS-1:0][WIDTH-1:0] asm_reg;
    logic [CHANNELS-1:0]            mask_reg;
    logic                           stall_reg;
    logic [CHANNELS-1:0][WIDTH-1:0] pdata_reg;
    logic                           valid_reg;
    logic                           miss_reg;
    logic                           dup_reg;
    logic                           over_reg;

    logic                           chan_in_range;
    logic                           accept;
    logic                           beat_en;
    logic                           stall_now;
    logic                           dup_now;
    logic [CHANNELS-1:0][WIDTH-1:0] merged;
    logic [CHANNELS-1:0]            eff_mask;

    // Only a narrower channel count can see indices that do not exist;
    // such beats are consumed but leave the frame untouched.
    generate
        if (CHANNELS == (1 << $bits(chan_t))) begin : g_full_idx
            assign chan_in_range = 1'b1;
        end else begin : g_part_idx
            assign chan_in_range = (int'(s_chan) < CHANNELS);
        end
    endgenerate

    // Gating with enable keeps a beat from being taken in the very cycle
    // the block is being cleared.
    assign s_ready   = enable && (state_reg == FILL);
    assign accept    = s_valid && s_ready;
    assign beat_en   = accept && chan_in_range;
    assign stall_now = enable && s_valid && !s_ready;
    assign dup_now   = beat_en && mask_reg[s_chan];

    frame_merge #(
        .CHANNELS     (CHANNELS),
        .WIDTH        (WIDTH),
        .HOLD_ON_MISS (HOLD_ON_MISS)
    ) u_merge (
        .asm_data  (asm_reg),
        .chan_mask (mask_reg),
        .beat_en   (beat_en),
        .beat_chan (s_chan),
        .beat_data (s_data),
        .old_pdata (pdata_reg),
        .merged    (merged),
        .eff_mask  (eff_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            asm_reg   <= '0;
            mask_reg  <= '0;
            stall_reg <= 1'b0;
            pdata_reg <= '0;
            valid_reg <= 1'b0;
            miss_reg  <= 1'b0;
            dup_reg   <= 1'b0;
            over_reg  <= 1'b0;
        end else if (!enable) begin
            // Soft clear: everything but the presented frame.
            state_reg <= IDLE;
            asm_reg   <= '0;
            mask_reg  <= '0;
            stall_reg <= 1'b0;
            valid_reg <= 1'b0;
            miss_reg  <= 1'b0;
            dup_reg   <= 1'b0;
            over_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            miss_reg  <= 1'b0;
            over_reg  <= 1'b0;
            dup_reg   <= dup_now;

            if (beat_en) begin
                asm_reg[s_chan] <= s_data;
            end

            if (frame_tick) begin
                // The beat taken in the tick cycle is already folded into
                // merged/eff_mask, so the new period starts empty.
                pdata_reg <= merged;
                valid_reg <= 1'b1;
                miss_reg  <= (eff_mask != FULL_MASK);
                over_reg  <= stall_reg || stall_now;
                mask_reg  <= '0;
                stall_reg <= 1'b0;
                state_reg <= FILL;
            end else begin
                mask_reg <= eff_mask;
                if (stall_now) begin
                    stall_reg <= 1'b1;
                end
                case (state_reg)
                    IDLE: state_reg <= FILL;
                    FILL: begin
                        if (accept && ((eff_mask == FULL_MASK) || s_last)) begin
                            state_reg <= FULL;
                        end
                    end
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

    assign valid       = valid_reg;
    assign pdata       = pdata_reg;
    assign missIncr    = miss_reg;
    assign dupIncr     = dup_reg;
    assign overrunIncr = over_reg;

endmodule
